// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// register address and data widths, the hard-wired zero register,
// and the grant encoding passed from the priority arbiter to the top.
package rf_wb_arbiter_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 1 << AW;

    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_prio_arb.sv
// Two-requester writeback priority arbiter. A (single-cycle ALU) normally
// wins. B (multi-cycle unit) wins when A is idle, or when B has been stalled
// for STARVE_MAX cycles. The grant is combinational from the valids and the
// starvation counter. No grant is given while rst is high.
module wb_prio_arb
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   a_valid,
    input  logic   b_valid,
    output grant_e grant
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] r_starve_cnt;
    logic          w_b_forced;
    logic          w_b_win;

    assign w_b_forced = b_valid && (r_starve_cnt == C_MAX);
    assign w_b_win    = b_valid && (!a_valid || w_b_forced);

    // Select the winner for this cycle. B wins only when A is idle or B is starved.
    always_comb begin
        grant = GRANT_NONE;
        if (!rst) begin
            if (w_b_win) begin
                grant = GRANT_B;
            end else if (a_valid) begin
                grant = GRANT_A;
            end
        end
    end

    // Count the cycles B has been stalled. Saturate at STARVE_MAX. Clear when B transfers or goes idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!b_valid || (grant == GRANT_B)) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != C_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with a destination scoreboard.
// Two writeback sources share one RF write port. Issue reserves destination
// registers, and those registers stay pending until their writeback transfers.
// Reads of pending registers raise hazard.
// Optional feature macro: RF_WB_BYPASS_EN. When it is defined, the value
// being written this cycle is forwarded to rd1/rd2 on an address match, and
// that read does not raise a hazard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rsv_valid,
    input  logic [AW-1:0] rsv_addr,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd3,
    input  logic [AW-1:0] rd_a1,
    input  logic [AW-1:0] rd_a2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          hazard,
    output logic [NREG-1:0] pending
);

    grant_e          w_grant;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_byp1;
    logic            w_byp2;
    logic            w_haz1;
    logic            w_haz2;
    logic [NREG-1:0] r_pending;

    wb_prio_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .grant   (w_grant)
    );

    assign a_ready = (w_grant == GRANT_A);
    assign b_ready = (w_grant == GRANT_B);
    assign w_xfer  = a_ready || b_ready;
    assign w_addr  = b_ready ? b_addr : a_addr;
    assign w_data  = b_ready ? b_data : a_data;

    // A transfer to the zero register is accepted but does not write the RF.
    assign rf_we  = w_xfer && (w_addr != ZERO_REG);
    assign rf_a3  = w_addr;
    assign rf_wd3 = w_data;

    // Each scoreboard bit is set by a reservation and cleared by a writeback.
    // The set has priority so a new owner is not lost. Bit 0 is always zero.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                // The zero register can never be pending.
                always_ff @(posedge clk) begin
                    r_pending[gi] <= 1'b0;
                end
            end else begin : g_bit
                logic w_set;
                logic w_clr;
                assign w_set = rsv_valid && (rsv_addr == AW'(gi));
                assign w_clr = w_xfer && (w_addr == AW'(gi));
                // Update one scoreboard bit. The reservation has priority over the clear.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_pending[gi] <= 1'b0;
                    end else if (w_set) begin
                        r_pending[gi] <= 1'b1;
                    end else if (w_clr) begin
                        r_pending[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign pending = r_pending;

`ifdef RF_WB_BYPASS_EN
    assign w_byp1 = rf_we && (rd_a1 == rf_a3);
    assign w_byp2 = rf_we && (rd_a2 == rf_a3);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_haz1 = (rd_a1 != ZERO_REG) && r_pending[rd_a1] && !w_byp1;
    assign w_haz2 = (rd_a2 != ZERO_REG) && r_pending[rd_a2] && !w_byp2;
    assign hazard = !rst && (w_haz1 || w_haz2);

    assign rd1 = w_byp1 ? rf_wd3 : rf_rd1;
    assign rd2 = w_byp2 ? rf_wd3 : rf_rd2;

endmodule
